// File: rtl/ring_scan_sequencer.sv
// Prescaled N-bit rotating ring for digit (anode) scanning, with parallel load,
// direction control, output polarity, a decoded position index and step/wrap pulses.
module ring_scan_sequencer #(
  parameter int            N             = 4,
  parameter logic [N-1:0]  INITIAL_VALUE = N'(1),
  parameter int            PRESCALE      = 16,
  parameter bit            ACTIVE_LOW    = 1'b0,
  localparam int           IW            = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_value,
  output logic [N-1:0]  parallel_out,
  output logic [IW-1:0] index,
  output logic          step,
  output logic          wrap
);

  localparam int            CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [N-1:0]  ring;
  logic [N-1:0]  ring_rot;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          wrap_bit;
  logic          step_q;
  logic          wrap_q;

  // With PRESCALE = 1 the counter is pinned at zero, so every enabled cycle ticks.
  assign tick = enable && (cnt == CNT_LAST);

  // dir = 0 moves bits toward the LSB (bit 0 re-enters at bit N-1); dir = 1 the opposite.
  always_comb begin
    ring_rot = ring;
    wrap_bit = 1'b0;
    if (dir) begin
      ring_rot = {ring[N-2:0], ring[N-1]};
      wrap_bit = ring[N-1];
    end else begin
      ring_rot = {ring[0], ring[N-1:1]};
      wrap_bit = ring[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ring   <= INITIAL_VALUE;
      cnt    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (load) begin
      ring   <= load_value;
      cnt    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (tick) begin
        ring <= ring_rot;
      end
      step_q <= tick;
      wrap_q <= tick & wrap_bit;
    end
  end

  // Lowest set bit wins; an all-zero ring reports position 0.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ring[i]) begin
        index = IW'(i);
      end
    end
  end

  assign parallel_out = ring ^ {N{ACTIVE_LOW}};
  assign step         = step_q;
  assign wrap         = wrap_q;

endmodule
